// File: rtl/tpu_ctrl_pkg.sv
// Shared types for the tpu job sequencer: data word, FSM state enum and count helpers.
package tpu_ctrl_pkg;

  localparam int DATA_WIDTH = 16;
  typedef logic [DATA_WIDTH-1:0] data_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR0,
    ST_LOAD_K,
    ST_LOAD_M,
    ST_CLR1,
    ST_COMPUTE,
    ST_FLUSH
  } state_e;

  function automatic int kn_count(input int conv_dim);
    return conv_dim * conv_dim;
  endfunction

  function automatic int mn_count(input int matrix_dim);
    return matrix_dim * matrix_dim;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Shift-register FIFO: entry 0 is the registered head, so rdata comes straight from a flop.
module sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    free_cnt
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign free_cnt = CW'(DEPTH) - cnt_q;
  assign rdata    = mem_q[0];
  // A full FIFO refuses the push even when a pop happens in the same cycle.
  assign do_pop   = pop && !empty;
  assign do_push  = push && !full;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i + 1];
      cnt_d = cnt_q - CW'(1);
    end
    if (do_push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == cnt_d) mem_d[i] = wdata;
      end
      cnt_d = cnt_d + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      // NOTE: storage is reset here because entry 0 drives out_data, which must read 0 after reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments only, so all flops see pre-edge values.
      cnt_q <= cnt_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: rtl/tpu_ctrl.sv
// Job sequencer for one tpu instance: loads kernal and matrix words, then streams framed results.
// Optional stall counter on perf_cycles is built only when TPU_CTRL_PERF_EN is defined.
module tpu_ctrl
  import tpu_ctrl_pkg::*;
#(
  parameter int MATRIX_DIM = 16,
  parameter int CONV_DIM   = 3,
  parameter int OUT_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        job_done,
  input  logic        in_valid,
  output logic        in_ready,
  input  data_t       in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output data_t       out_data,
  output logic        out_last,
  output logic        overflow,
  output logic        tpu_rst,
  output logic        tpu_insert_kernal,
  output logic        tpu_write_mode,
  output logic        tpu_write,
  output logic        tpu_ready,
  output data_t       tpu_data_in,
  input  logic        tpu_done,
  input  data_t       tpu_data_out
`ifdef TPU_CTRL_PERF_EN
  ,
  output logic [31:0] perf_cycles
`endif
);

  localparam int KN  = kn_count(CONV_DIM);
  localparam int MN  = mn_count(MATRIX_DIM);
  localparam int RN  = mn_count(MATRIX_DIM);
  localparam int WCW = $clog2(MN) + 1;
  localparam int RCW = $clog2(RN) + 1;
  localparam int FCW = $clog2(OUT_DEPTH + 1);

  state_e             state_q, state_d;
  logic [WCW-1:0]     word_cnt_q, word_cnt_d;
  logic [RCW-1:0]     res_cnt_q, res_cnt_d;
  logic               overflow_q, overflow_d;
  logic               fifo_push, fifo_full, fifo_empty;
  logic [FCW-1:0]     fifo_free;
  logic [DATA_WIDTH:0] fifo_wdata, fifo_rdata;

  assign fifo_wdata  = {res_cnt_q == RCW'(RN - 1), tpu_data_out};
  assign tpu_data_in = in_data;
  assign tpu_rst     = rst | (state_q == ST_CLR0);
  assign busy        = (state_q != ST_IDLE);
  assign overflow    = overflow_q;
  assign out_valid   = !fifo_empty;
  assign {out_last, out_data} = fifo_rdata;

  always_comb begin
    state_d           = state_q;
    word_cnt_d        = word_cnt_q;
    res_cnt_d         = res_cnt_q;
    overflow_d        = overflow_q;
    in_ready          = 1'b0;
    tpu_write         = 1'b0;
    tpu_insert_kernal = 1'b0;
    tpu_ready         = 1'b0;
    tpu_write_mode    = 1'b1;
    fifo_push         = 1'b0;
    job_done          = 1'b0;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_CLR0;
      ST_CLR0: state_d = ST_LOAD_K;
      ST_LOAD_K, ST_LOAD_M: begin
        in_ready          = 1'b1;
        tpu_ready         = 1'b1;
        tpu_write         = in_valid;
        tpu_insert_kernal = (state_q == ST_LOAD_K);
        if (in_valid) begin
          word_cnt_d = word_cnt_q + WCW'(1);
          if (state_q == ST_LOAD_K && word_cnt_q == WCW'(KN - 1)) state_d = ST_LOAD_M;
          if (state_q == ST_LOAD_M && word_cnt_q == WCW'(MN - 1)) state_d = ST_CLR1;
        end
      end
      ST_CLR1: state_d = ST_COMPUTE;
      ST_COMPUTE: begin
        tpu_write_mode = 1'b0;
        // Two free slots cover a result already in flight when tpu_ready drops.
        tpu_ready      = (fifo_free >= FCW'(2));
        if (tpu_done) begin
          fifo_push  = !fifo_full;
          overflow_d = overflow_q | fifo_full;
          res_cnt_d  = res_cnt_q + RCW'(1);
          if (res_cnt_q == RCW'(RN - 1)) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (fifo_empty) begin
          state_d  = ST_IDLE;
          job_done = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state_q) word_cnt_d = '0;
    if (state_q != ST_COMPUTE) res_cnt_d = '0;
    if (rst) begin
      in_ready          = 1'b0;
      tpu_write         = 1'b0;
      tpu_insert_kernal = 1'b0;
      tpu_ready         = 1'b0;
      tpu_write_mode    = 1'b0;
      job_done          = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      word_cnt_q <= '0;
      res_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      res_cnt_q  <= res_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH(DATA_WIDTH + 1),
    .DEPTH(OUT_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wdata   (fifo_wdata),
    .pop     (out_ready),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .free_cnt(fifo_free)
  );

`ifdef TPU_CTRL_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (state_q == ST_CLR0) perf_d = '0;
    else if (state_q == ST_COMPUTE && !tpu_ready && perf_q != '1) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_tpu_ctrl.sv
// Randomised bench for tpu_ctrl: queue-based job model checked every cycle plus literal per-scenario expectations.
module tb_tpu_ctrl;
  import tpu_ctrl_pkg::*;

  localparam int MD = 4;
  localparam int CD = 3;
  localparam int DEPTH = 4;
  localparam int KN = CD * CD;
  localparam int MN = MD * MD;
  localparam int RN = MD * MD;

  localparam int P_IDLE = 0, P_CLR0 = 1, P_LOADK = 2, P_LOADM = 3, P_CLR1 = 4, P_COMP = 5, P_FLUSH = 6;
  localparam int M_BASIC = 0, M_BUBBLE = 1, M_BACKP = 2, M_OVF = 3, M_RAND = 4, M_RSTMID = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, job_done;
  logic in_valid = 1'b0;
  logic in_ready;
  data_t in_data = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  data_t out_data;
  logic out_last, overflow;
  logic tpu_rst, tpu_insert_kernal, tpu_write_mode, tpu_write, tpu_ready;
  data_t tpu_data_in;
  logic tpu_done = 1'b0;
  data_t tpu_data_out = '0;
`ifdef TPU_CTRL_PERF_EN
  logic [31:0] perf_cycles;
`endif

  always #5 clk = ~clk;

  tpu_ctrl #(.MATRIX_DIM(MD), .CONV_DIM(CD), .OUT_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .job_done(job_done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .overflow(overflow), .tpu_rst(tpu_rst), .tpu_insert_kernal(tpu_insert_kernal),
    .tpu_write_mode(tpu_write_mode), .tpu_write(tpu_write), .tpu_ready(tpu_ready),
    .tpu_data_in(tpu_data_in), .tpu_done(tpu_done), .tpu_data_out(tpu_data_out)
`ifdef TPU_CTRL_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: job phase, word/result counts and the result FIFO as a queue.
  typedef struct packed {
    logic  last;
    data_t d;
  } ent_t;

  ent_t        m_q[$];
  int          m_phase = P_IDLE;
  int          m_k, m_m, m_r;
  bit          m_ovf, m_valid;
  logic [31:0] m_perf;

  function automatic bit exp_ready();
    if (rst) return 1'b0;
    if (m_phase == P_LOADK || m_phase == P_LOADM) return 1'b1;
    return (m_phase == P_COMP) && (DEPTH - m_q.size() >= 2);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_phase = P_IDLE;
      m_q.delete();
      m_ovf = 1'b0;
      m_perf = '0;
      m_k = 0; m_m = 0; m_r = 0;
    end else if (m_valid) begin
      int occ;
      bit pop, push, rdy;
      ent_t e;
      occ = m_q.size();
      pop = (occ > 0) && out_ready;
      rdy = exp_ready();
      push = 1'b0;
      e = '0;
      case (m_phase)
        P_IDLE: if (start) m_phase = P_CLR0;
        P_CLR0: begin m_perf = '0; m_k = 0; m_m = 0; m_phase = P_LOADK; end
        P_LOADK: if (in_valid) begin m_k++; if (m_k == KN) m_phase = P_LOADM; end
        P_LOADM: if (in_valid) begin m_m++; if (m_m == MN) m_phase = P_CLR1; end
        P_CLR1: begin m_r = 0; m_phase = P_COMP; end
        P_COMP: begin
          if (!rdy && m_perf != 32'hFFFF_FFFF) m_perf++;
          if (tpu_done) begin
            m_r++;
            if (occ == DEPTH) m_ovf = 1'b1;
            else begin push = 1'b1; e.d = tpu_data_out; e.last = (m_r == RN); end
            if (m_r == RN) m_phase = P_FLUSH;
          end
        end
        P_FLUSH: if (occ == 0) m_phase = P_IDLE;
        default: m_phase = P_IDLE;
      endcase
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back(e);
    end
  end

  // Observation counters, advanced once per cycle at the falling edge.
  int n_write = 0, n_ins = 0, n_out = 0, n_last = 0, n_done = 0;

  always @(negedge clk) begin
    if (m_valid) begin
      int occ;
      bit ld;
      occ = m_q.size();
      ld = !rst && (m_phase == P_LOADK || m_phase == P_LOADM);
      check("busy", busy, m_phase != P_IDLE);
      check("in_ready", in_ready, ld);
      check("tpu_write", tpu_write, ld && in_valid);
      check("tpu_insert_kernal", tpu_insert_kernal, !rst && m_phase == P_LOADK);
      check("tpu_ready", tpu_ready, exp_ready());
      check("tpu_write_mode", tpu_write_mode, !rst && m_phase != P_COMP);
      check("tpu_rst", tpu_rst, rst || m_phase == P_CLR0);
      check("tpu_data_in", tpu_data_in, in_data);
      check("job_done", job_done, !rst && m_phase == P_FLUSH && occ == 0);
      check("out_valid", out_valid, occ > 0);
      check("overflow", overflow, m_ovf);
      if (occ > 0) begin
        check("out_data", out_data, m_q[0].d);
        check("out_last", out_last, m_q[0].last);
      end
`ifdef TPU_CTRL_PERF_EN
      check("perf_cycles", perf_cycles, m_perf);
`endif
    end
    n_write += int'(tpu_write);
    n_ins   += int'(tpu_write && tpu_insert_kernal);
    n_out   += int'(out_valid && out_ready);
    n_last  += int'(out_valid && out_ready && out_last);
    n_done  += int'(job_done);
  end

  task automatic run_job(input int mode, output int dw, output int di, output int dout,
                         output int dlast, output int dd);
    int w0, i0, o0, l0, d0, stalls, dn, acc;
    bit released, timed_out, comp;
    w0 = n_write; i0 = n_ins; o0 = n_out; l0 = n_last; d0 = n_done;
    stalls = 0; dn = 0; acc = 0; released = 1'b0; timed_out = 1'b1;
    in_valid = 1'b0; tpu_done = 1'b0; out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (n_done != d0) begin timed_out = 1'b0; break; end
      if (mode == M_RSTMID && acc == KN + 5) begin timed_out = 1'b0; break; end
      comp = busy && !tpu_write_mode;
      in_data = data_t'($urandom);
      tpu_data_out = data_t'($urandom);
      case (mode)
        M_BASIC: begin in_valid = 1'b1; out_ready = 1'b1; tpu_done = comp && tpu_ready; end
        M_BUBBLE: begin in_valid = (cyc % 2 == 0); out_ready = 1'b1; tpu_done = comp && tpu_ready; end
        M_BACKP: begin
          if (!released && stalls == 10) begin
`ifdef TPU_CTRL_PERF_EN
            check("perf_after_10_stalls", perf_cycles, 32'd10);
`endif
            released = 1'b1;
          end
          in_valid = 1'b1;
          out_ready = released;
          tpu_done = comp && tpu_ready;
          if (comp && !tpu_ready) begin
            if (stalls == 0) check("dones_at_first_stall", dn, 3);
            stalls++;
          end
        end
        M_OVF: begin in_valid = 1'b1; out_ready = !comp; tpu_done = comp; end
        M_RAND: begin
          in_valid = ($urandom % 4 != 0);
          out_ready = ($urandom % 4 != 0);
          tpu_done = ($urandom % 2 == 0);
          start = ($urandom % 4 == 0);
        end
        default: begin in_valid = 1'b1; out_ready = 1'b1; tpu_done = 1'b0; end
      endcase
      if (tpu_done && comp) dn++;
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
    end
    start = 1'b0; in_valid = 1'b0; tpu_done = 1'b0; out_ready = 1'b1;
    check("job_timeout", timed_out, 1'b0);
    if (mode == M_RSTMID) begin
      rst = 1'b1;
      @(posedge clk); #1;
      check("rstmid_busy", busy, 1'b0);
      check("rstmid_out_valid", out_valid, 1'b0);
      rst = 1'b0;
    end
    dw = n_write - w0; di = n_ins - i0; dout = n_out - o0; dlast = n_last - l0; dd = n_done - d0;
  endtask

  initial begin
    int dw, di, dout, dlast, dd;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_busy", busy, 1'b0);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_data", out_data, '0);
    check("reset_overflow", overflow, 1'b0);
    @(posedge clk); #1;

    run_job(M_BASIC, dw, di, dout, dlast, dd);
    check("basic_writes", dw, 25);
    check("basic_insert_kernal", di, 9);
    check("basic_results", dout, 16);
    check("basic_last", dlast, 1);
    check("basic_job_done", dd, 1);

    run_job(M_BUBBLE, dw, di, dout, dlast, dd);
    check("bubble_writes", dw, 25);
    check("bubble_insert_kernal", di, 9);
    check("bubble_job_done", dd, 1);

    run_job(M_BACKP, dw, di, dout, dlast, dd);
    check("backp_results", dout, 16);
    check("backp_last", dlast, 1);
    check("backp_overflow", overflow, 1'b0);

    run_job(M_OVF, dw, di, dout, dlast, dd);
    check("ovf_flag", overflow, 1'b1);
    check("ovf_results_kept", dout, DEPTH);
    check("ovf_last_dropped", dlast, 0);
    check("ovf_job_done", dd, 1);

    run_job(M_BASIC, dw, di, dout, dlast, dd);
    check("ovf_sticky", overflow, 1'b1);
    check("post_ovf_results", dout, 16);

    run_job(M_RSTMID, dw, di, dout, dlast, dd);
    check("rstmid_no_job_done", dd, 0);
    check("rstmid_overflow_cleared", overflow, 1'b0);
    run_job(M_BASIC, dw, di, dout, dlast, dd);
    check("clean_writes", dw, 25);
    check("clean_results", dout, 16);
    check("clean_job_done", dd, 1);

    for (int j = 0; j < 6; j++) begin
      run_job(M_RAND, dw, di, dout, dlast, dd);
      check("rand_job_done", dd, 1);
      check("rand_writes", dw, 25);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
